core_sequencer: RTL

- Multi-cycle control FSM for the 8-bit RISC core.
- Fetches an instruction over a req/ack instruction-memory port and holds it in the instruction register. The combinational decoder reads the register.
- Sequences execute, data memory access and register write-back, and owns the PC.
- Resolves BLT/BEQ/JMP. A self-jump halts the core.

---
 rtl/core_pkg.sv | 32 +++
 rtl/core_sequencer_pc_unit.sv | 45 ++++
 rtl/core_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared opcode map, FSM state encoding and write-back select codes for the 8-bit core sequencer.
package core_pkg;

  localparam logic [2:0] OP_LOGIC = 3'b000;
  localparam logic [2:0] OP_BLT   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_ARITH = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_BEQ   = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_JMP   = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_MOVE = 2'd2;

  // JMP shares opcode 111 with MOVE; fn bit (instr[3]) selects JMP.
  function automatic logic is_jump(input logic [7:0] ins);
    return (ins[2:0] == OP_JMP) && ins[3];
  endfunction

endpackage

// File: rtl/core_sequencer_pc_unit.sv
// pc_unit: PC and instruction-PC registers, +1 on fetch, sign-extended branch/jump target.
// Latency: pc updates on the clock after fetch_ack/take. Backpressure: none, pure register.
// Arithmetic is modulo 2^PC_W in both directions.
module pc_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ack,
  input  logic            take,
  input  logic [3:0]      imm,
  input  logic            wide_imm,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] ipc;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;

  // Branches use a 3-bit offset, jumps the full 4 bits; both relative to the fetched PC.
  always_comb begin
    offset = {{(PC_W-3){imm[2]}}, imm[2:0]};
    if (wide_imm) begin
      offset = {{(PC_W-4){imm[3]}}, imm};
    end
  end

  assign target = ipc + offset;
  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      ipc <= RESET_PC;
    end else if (fetch_ack) begin
      ipc <= pc;
      pc  <= pc_inc;
    end else if (take) begin
      pc <= target;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM for the 8-bit core.
// Latency (zero-wait memories): branch/jump 3, ALU/MOVE 4, STORE 4, LOAD 5 cycles.
// Backpressure: FETCH and MEM hold their request until ack; SINGLE_STEP_EN adds a step input.
module core_sequencer
  import core_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      instr,
  input  logic [3:0]      imm,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  output logic            alu_en,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [2:0]      state
);

  state_t     cur;
  state_t     nxt;
  state_t     retire_st;
  logic [2:0] op;
  logic       jmp;
  logic       br_taken;
  logic       take;
  logic       fetch_ack;
  logic       start;
  logic       park;

  assign op  = instr[2:0];
  assign jmp = is_jump(instr);

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic unused_run;

  assign unused_run = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // One instruction per rising edge of step; always park afterwards.
  assign start = step & ~step_q;
  assign park  = 1'b1;
`else
  assign start = run;
  assign park  = ~run;
`endif

  assign retire_st = park ? IDLE : FETCH;
  assign br_taken  = ((op == OP_BLT) && cmp_lt) || ((op == OP_BEQ) && cmp_eq);
  assign take      = (cur == EXEC) && (br_taken || jmp);
  assign fetch_ack = (cur == FETCH) && imem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= 8'h00;
    end else if (fetch_ack) begin
      instr <= imem_rdata;
    end
  end

  // Strobes decode from the registered state only, so reset drops them asynchronously.
  always_comb begin
    nxt      = cur;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    halted   = 1'b0;
    case (cur)
      IDLE: begin
        if (start) begin
          nxt = FETCH;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          nxt = DECODE;
        end
      end
      DECODE: begin
        nxt = EXEC;
      end
      EXEC: begin
        alu_en = 1'b1;
        case (op)
          OP_LOAD, OP_STORE: nxt = MEM;
          OP_BLT, OP_BEQ:    nxt = retire_st;
          OP_JMP: begin
            if (!jmp) begin
              nxt = WB;
            end else if (imm == 4'h0) begin
              nxt = HALT;
            end else begin
              nxt = retire_st;
            end
          end
          default:           nxt = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_STORE);
        if (dmem_ack) begin
          nxt = (op == OP_LOAD) ? WB : retire_st;
        end
      end
      WB: begin
        rf_we = 1'b1;
        if (op == OP_LOAD) begin
          wb_sel = WB_LOAD;
        end else if (op == OP_JMP) begin
          wb_sel = WB_MOVE;
        end
        nxt = retire_st;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  pc_unit #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_ack(fetch_ack),
    .take     (take),
    .imm      (imm),
    .wide_imm (jmp),
    .pc       (pc)
  );

  assign imem_addr = pc;
  assign state     = cur;

endmodule
